// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control-step sequencer: opcode values, the
// T-state enum, decoder result types and bus-source bit positions.
// Optional feature macro: CTRL_SINGLE_STEP_EN (adds the STEPW state).
package control_sequencer_pkg;

    // Opcode field ir[31:27]
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_SHR  = 5'b00011;
    localparam logic [4:0] OP_SHRA = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Bit positions inside the one-hot bus source select
    localparam int SRC_R0  = 0;
    localparam int SRC_ZLO = 19;
    localparam int SRC_PC  = 20;
    localparam int SRC_MDR = 21;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT,
        S_FAULT
`ifdef CTRL_SINGLE_STEP_EN
        , S_STEPW
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_BIN,
        CLS_NOT,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    typedef enum logic [2:0] {
        ALU_NONE,
        ALU_AND,
        ALU_OR,
        ALU_SHR,
        ALU_SHRA,
        ALU_SHL,
        ALU_NOT
    } alu_op_t;

    typedef struct packed {
        op_class_t   cls;
        alu_op_t     alu;
        logic [15:0] ra_oh;
        logic [15:0] rb_oh;
        logic [15:0] rc_oh;
        logic        legal;
    } decode_t;

    function automatic logic [15:0] reg_onehot(input logic [3:0] r);
        return 16'b1 << r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Connection between the control sequencer and the datapath/memory.
//   run, ir, mem_ready           : datapath -> sequencer
//   mem_rd, enc_sel, r_in,
//   y_in, zlo_in, mdr_in,
//   read_mdr, ir_in, pc_inc      : sequencer -> datapath control strobes
//   alu_*                        : ALU op lines (at most one high)
//   halted, fault                : sticky status
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic        mem_rd;
    logic [31:0] enc_sel;
    logic [15:0] r_in;
    logic        y_in;
    logic        zlo_in;
    logic        mdr_in;
    logic        read_mdr;
    logic        ir_in;
    logic        pc_inc;
    logic        alu_and;
    logic        alu_or;
    logic        alu_not;
    logic        alu_shr;
    logic        alu_shra;
    logic        alu_shl;
    logic        halted;
    logic        fault;

    modport master (
        input  run, ir, mem_ready,
        output mem_rd, enc_sel, r_in, y_in, zlo_in, mdr_in, read_mdr, ir_in,
               pc_inc, alu_and, alu_or, alu_not, alu_shr, alu_shra, alu_shl,
               halted, fault
    );

    modport slave (
        output run, ir, mem_ready,
        input  mem_rd, enc_sel, r_in, y_in, zlo_in, mdr_in, read_mdr, ir_in,
               pc_inc, alu_and, alu_or, alu_not, alu_shr, alu_shra, alu_shl,
               halted, fault
    );
endinterface

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational instruction decoder.
//   ir  : instruction word (op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15])
//   dec : operation class, ALU op, one-hot register selects, legal flag
module control_sequencer_instr_decoder
    import control_sequencer_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec
);
    // Low instruction bits carry no control information.
    logic unused_low_bits;
    assign unused_low_bits = ^ir[14:0];

    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        dec.cls   = CLS_ILL;
        dec.alu   = ALU_NONE;
        dec.legal = 1'b1;
        dec.ra_oh = reg_onehot(ir[26:23]);
        dec.rb_oh = reg_onehot(ir[22:19]);
        dec.rc_oh = reg_onehot(ir[18:15]);
        case (ir[31:27])
            OP_NOP:  dec.cls = CLS_NOP;
            OP_AND:  begin dec.cls = CLS_BIN; dec.alu = ALU_AND;  end
            OP_OR:   begin dec.cls = CLS_BIN; dec.alu = ALU_OR;   end
            OP_SHR:  begin dec.cls = CLS_BIN; dec.alu = ALU_SHR;  end
            OP_SHRA: begin dec.cls = CLS_BIN; dec.alu = ALU_SHRA; end
            OP_SHL:  begin dec.cls = CLS_BIN; dec.alu = ALU_SHL;  end
            OP_NOT:  begin dec.cls = CLS_NOT; dec.alu = ALU_NOT;  end
            OP_HALT: dec.cls = CLS_HALT;
            default: dec.legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Control-step sequencer for the bus-based datapath. Steps fetch (T0..T2),
// decode (T3) and execute (T4, T5), waits on mem_ready in T0 with a timeout,
// and parks in HALT or FAULT until clr.
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset
//   step : (only with CTRL_SINGLE_STEP_EN) each rising edge releases one instruction
//   bus  : control_sequencer_if.master (inputs run/ir/mem_ready, all strobes out)
// Parameter MEM_TIMEOUT: T0 cycles allowed without mem_ready before FAULT (1..255).
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    decode_t    dec;

    control_sequencer_instr_decoder u_instr_decoder (
        .ir  (bus.ir),
        .dec (dec)
    );

`ifdef CTRL_SINGLE_STEP_EN
    // A rising step seen while an instruction is still running is remembered,
    // so every pulse releases exactly one instruction.
    logic step_q, step_pend, step_go;
    assign step_go = step_pend | (step & ~step_q);
    localparam state_t S_NEXT = S_STEPW;

    always_ff @(posedge clk) begin
        if (clr) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= step;
            if (state == S_STEPW && step_go)
                step_pend <= 1'b0;
            else if (step & ~step_q)
                step_pend <= 1'b1;
        end
    end
`else
    localparam state_t S_NEXT = S_T0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state. wait_cnt only advances while T0 is stalled; it is zero on
    // every T0 entry. mem_ready is tested first so it beats the timeout.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            S_IDLE: if (bus.run) state_nxt = S_NEXT;
            S_T0: begin
                if (bus.mem_ready)
                    state_nxt = S_T1;
                else if (wait_cnt == TIMEOUT_LAST)
                    state_nxt = S_FAULT;
                else
                    wait_cnt_nxt = wait_cnt + 8'd1;
            end
            S_T1: state_nxt = S_T2;
            S_T2: state_nxt = S_T3;
            S_T3: begin
                if (!dec.legal)
                    state_nxt = S_FAULT;
                else case (dec.cls)
                    CLS_BIN, CLS_NOT: state_nxt = S_T4;
                    CLS_HALT:         state_nxt = S_HALT;
                    CLS_NOP:          state_nxt = S_NEXT;
                    default:          state_nxt = S_FAULT;
                endcase
            end
            S_T4: state_nxt = S_T5;
            S_T5: state_nxt = bus.run ? S_NEXT : S_IDLE;
            S_HALT, S_FAULT: state_nxt = state;
`ifdef CTRL_SINGLE_STEP_EN
            S_STEPW: if (step_go) state_nxt = S_T0;
`endif
            default: state_nxt = S_FAULT;
        endcase
    end

    // Moore output decode; operand selects come from the held IR.
    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.enc_sel  = '0;
        bus.r_in     = '0;
        bus.y_in     = 1'b0;
        bus.zlo_in   = 1'b0;
        bus.mdr_in   = 1'b0;
        bus.read_mdr = 1'b0;
        bus.ir_in    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.alu_and  = 1'b0;
        bus.alu_or   = 1'b0;
        bus.alu_not  = 1'b0;
        bus.alu_shr  = 1'b0;
        bus.alu_shra = 1'b0;
        bus.alu_shl  = 1'b0;
        bus.halted   = 1'b0;
        bus.fault    = 1'b0;
        case (state)
            S_T0: begin
                bus.mem_rd          = 1'b1;
                bus.enc_sel[SRC_PC] = 1'b1;
            end
            S_T1: begin
                bus.read_mdr = 1'b1;
                bus.mdr_in   = 1'b1;
                bus.pc_inc   = 1'b1;
            end
            S_T2: begin
                bus.enc_sel[SRC_MDR] = 1'b1;
                bus.ir_in            = 1'b1;
            end
            S_T3: begin
                // NOT has a single operand and goes straight to the ALU in T4.
                if (dec.cls == CLS_BIN) begin
                    bus.enc_sel[SRC_R0 +: 16] = dec.rb_oh;
                    bus.y_in                  = 1'b1;
                end
            end
            S_T4: begin
                bus.enc_sel[SRC_R0 +: 16] = (dec.cls == CLS_NOT) ? dec.rb_oh : dec.rc_oh;
                bus.zlo_in = 1'b1;
                case (dec.alu)
                    ALU_AND:  bus.alu_and  = 1'b1;
                    ALU_OR:   bus.alu_or   = 1'b1;
                    ALU_SHR:  bus.alu_shr  = 1'b1;
                    ALU_SHRA: bus.alu_shra = 1'b1;
                    ALU_SHL:  bus.alu_shl  = 1'b1;
                    ALU_NOT:  bus.alu_not  = 1'b1;
                    default:  ;
                endcase
            end
            S_T5: begin
                bus.enc_sel[SRC_ZLO] = 1'b1;
                bus.r_in             = dec.ra_oh;
            end
            S_HALT:  bus.halted = 1'b1;
            S_FAULT: bus.fault  = 1'b1;
            default: ;
        endcase
    end
endmodule
